// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative row multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Clock cycles spent in RUN for one product; 0 flags an illegal row count.
    function automatic int unsigned cycles_per_op(input int unsigned n, input int unsigned r);
        if (r == 0) begin
            return 0;
        end
        return n / r;
    endfunction

endpackage

// File: rtl/pp_row_step.sv
// One shift-add row: adds the gated (optionally negated) multiplicand to the
// running high half and shifts the sum right by one bit.
module pp_row_step #(
    parameter int unsigned N = 8
) (
    input  logic [N:0]   hi_i,
    input  logic         lo0_i,
    input  logic [N-1:0] a_i,
    input  logic         sgn_i,
    input  logic         negate_i,
    output logic [N:0]   hi_o,
    output logic         bit_o
);

    logic [N+1:0] hi_ext;
    logic [N+1:0] a_ext;
    logic [N+1:0] opnd;
    logic [N+1:0] sum;
    logic [N+1:0] carry;

    always_comb begin
        hi_ext = {sgn_i & hi_i[N], hi_i};
        a_ext  = {{2{sgn_i & a_i[N-1]}}, a_i};
        opnd   = '0;
        carry  = '0;
        sum    = '0;
        // Subtracting the multiplicand is ~a plus a carry-in of one.
        if (lo0_i) begin
            opnd     = negate_i ? ~a_ext : a_ext;
            carry[0] = negate_i;
        end
        for (int i = 0; i < N + 1; i++) begin
            sum[i]       = hi_ext[i] ^ opnd[i] ^ carry[i];
            carry[i + 1] = (hi_ext[i] & opnd[i]) | (carry[i] & (hi_ext[i] ^ opnd[i]));
        end
        sum[N+1] = hi_ext[N+1] ^ opnd[N+1] ^ carry[N+1];
    end

    assign hi_o  = sum[N+1:1];
    assign bit_o = sum[0];

endmodule

// File: rtl/iter_row_multiplier.sv
// Iterative NxN multiplier: ROWS_PER_CYCLE shift-add rows reused per clock,
// valid/ready handshakes on both sides, unsigned or signed per transaction.
module iter_row_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned N              = 8,
    parameter int unsigned ROWS_PER_CYCLE = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    input  logic           is_signed_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [2*N-1:0] p_o
);

    localparam int unsigned R      = ROWS_PER_CYCLE;
    localparam int unsigned CntW   = $clog2(N + 1);
    localparam int unsigned Cycles = cycles_per_op(N, R);

    if (N < 2 || R < 1 || R > N || Cycles * R != N) begin : g_param_err
        $error("iter_row_multiplier: ROWS_PER_CYCLE must divide N, and N >= 2");
    end

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic            sgn_q, sgn_d;
    logic [N:0]      hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Row chain: stage k feeds stage k+1 combinationally within one clock.
    logic [N:0]   hi_c [R+1];
    logic [N-1:0] lo_c [R+1];

    assign hi_c[0] = hi_q;
    assign lo_c[0] = lo_q;

    for (genvar k = 0; k < R; k++) begin : g_row
        logic bit_out;
        logic negate;

        // The multiplier MSB carries negative weight in signed mode.
        assign negate = sgn_q && ((32'(cnt_q) + 32'(k)) == (N - 1));

        pp_row_step #(
            .N(N)
        ) u_row (
            .hi_i    (hi_c[k]),
            .lo0_i   (lo_c[k][0]),
            .a_i     (a_q),
            .sgn_i   (sgn_q),
            .negate_i(negate),
            .hi_o    (hi_c[k+1]),
            .bit_o   (bit_out)
        );

        assign lo_c[k+1] = {bit_out, lo_c[k][N-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    sgn_d   = is_signed_i;
                    lo_d    = b_i;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                hi_d  = hi_c[R];
                lo_d  = lo_c[R];
                cnt_d = cnt_q + CntW'(R);
                if (cnt_d == CntW'(N)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    hi_d    = '0;
                    lo_d    = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign p_o         = (state_q == StDone) ? {hi_q[N-1:0], lo_q} : '0;

endmodule

// File: tb/tb_iter_row_multiplier.sv
// Directed and random checks of iter_row_multiplier for ROWS_PER_CYCLE 1, 2, 4, 8.
module tb_iter_row_multiplier;

    localparam int unsigned N    = 8;
    localparam int          NDUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst;
    logic         in_valid_s  [NDUT];
    logic         in_ready_s  [NDUT];
    logic         is_signed_s [NDUT];
    logic         out_valid_s [NDUT];
    logic         out_ready_s [NDUT];
    logic [N-1:0] a_s         [NDUT];
    logic [N-1:0] b_s         [NDUT];
    logic [2*N-1:0] p_s       [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        iter_row_multiplier #(
            .N             (N),
            .ROWS_PER_CYCLE(1 << g)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .in_valid_i (in_valid_s[g]),
            .in_ready_o (in_ready_s[g]),
            .a_i        (a_s[g]),
            .b_i        (b_s[g]),
            .is_signed_i(is_signed_s[g]),
            .out_valid_o(out_valid_s[g]),
            .out_ready_i(out_ready_s[g]),
            .p_o        (p_s[g])
        );
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sg;
        logic [15:0] p;
        string       name;
    } vec_t;

    vec_t vecs [14];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic sg);
        logic signed [15:0] sa, sb;
        if (sg) begin
            sa = {{8{a[7]}}, a};
            sb = {{8{b[7]}}, b};
            return 16'(sa * sb);
        end
        return 16'({8'b0, a} * {8'b0, b});
    endfunction

    // Called at #1 after an edge with the DUT idle; returns with it idle again.
    task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                          input logic sg, input logic [15:0] exp, input string name);
        int lat;
        in_valid_s[d]  = 1'b1;
        a_s[d]         = a;
        b_s[d]         = b;
        is_signed_s[d] = sg;
        chk({name, "/in_ready"}, 32'(in_ready_s[d]), 32'd1);
        @(posedge clk);
        #1;
        in_valid_s[d]  = 1'b0;
        a_s[d]         = ~a;
        b_s[d]         = ~b;
        is_signed_s[d] = ~sg;
        lat = 0;
        while (!out_valid_s[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "/latency"}, 32'(lat), 32'(8 >> d));
        chk({name, "/p"}, 32'(p_s[d]), 32'(exp));
        out_ready_s[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s[d] = 1'b0;
        chk({name, "/idle"}, {30'b0, in_ready_s[d], out_valid_s[d]}, 32'b10);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ra, rb;
        logic        rs;
        logic [7:0]  ba [4];
        logic [7:0]  bb [4];
        logic [15:0] bexp [4];
        int unsigned acc [4];
        int          k, j, t, lat;
        bit          adv;

        vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_255x255"};
        vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000, "s_m128xm128"};
        vecs[2]  = '{8'h7F, 8'h80, 1'b1, 16'hC080, "s_127xm128"};
        vecs[3]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_m1x1"};
        vecs[4]  = '{8'h00, 8'hB3, 1'b1, 16'h0000, "s_0xm77"};
        vecs[5]  = '{8'hC8, 8'h03, 1'b0, 16'h0258, "u_200x3"};
        vecs[6]  = '{8'h0D, 8'h0B, 1'b0, 16'h008F, "u_13x11"};
        vecs[7]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1xm1"};
        vecs[8]  = '{8'h80, 8'h7F, 1'b1, 16'hC080, "s_m128x127"};
        vecs[9]  = '{8'h80, 8'h01, 1'b1, 16'hFF80, "s_m128x1"};
        vecs[10] = '{8'h80, 8'hFF, 1'b0, 16'h7F80, "u_128x255"};
        vecs[11] = '{8'h64, 8'hFD, 1'b1, 16'hFED4, "s_100xm3"};
        vecs[12] = '{8'hFF, 8'h80, 1'b1, 16'h0080, "s_m1xm128"};
        vecs[13] = '{8'h07, 8'h09, 1'b0, 16'h003F, "u_7x9"};

        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid_s[d]  = 1'b0;
            out_ready_s[d] = 1'b0;
            a_s[d]         = '0;
            b_s[d]         = '0;
            is_signed_s[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("reset/d%0d", d),
                {13'b0, in_ready_s[d], out_valid_s[d], 1'b0, p_s[d]}, 32'h0004_0000);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table on every row configuration.
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 14; i++) begin
                run_op(d, vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].p,
                       $sformatf("%s/d%0d", vecs[i].name, d));
            end
        end

        // Random operands against a behavioural product.
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 150; i++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rs = 1'($urandom_range(0, 1));
                run_op(d, ra, rb, rs, ref_mul(ra, rb, rs),
                       $sformatf("rand/d%0d/%0h*%0h/s%0d", d, ra, rb, rs));
            end
        end

        // Backpressure: DONE held while out_ready is low, in_valid toggling.
        in_valid_s[0]  = 1'b1;
        a_s[0]         = 8'd37;
        b_s[0]         = 8'd5;
        is_signed_s[0] = 1'b0;
        @(posedge clk);
        #1;
        in_valid_s[0] = 1'b0;
        lat = 0;
        while (!out_valid_s[0] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp/arrive", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            in_valid_s[0] = ~in_valid_s[0];
            a_s[0]        = 8'hAA;
            b_s[0]        = 8'h55;
            @(posedge clk);
            #1;
            chk($sformatf("bp/hold%0d", i),
                {14'b0, in_ready_s[0], out_valid_s[0], p_s[0]}, 32'h0001_00B9);
        end
        in_valid_s[0]  = 1'b0;
        out_ready_s[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s[0] = 1'b0;
        chk("bp/release", {14'b0, in_ready_s[0], out_valid_s[0], p_s[0]}, 32'h0002_0000);

        // Reset in the third RUN cycle discards the operation.
        in_valid_s[0] = 1'b1;
        a_s[0]        = 8'd99;
        b_s[0]        = 8'd99;
        @(posedge clk);
        #1;
        in_valid_s[0] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_run/state", {14'b0, in_ready_s[0], out_valid_s[0], p_s[0]}, 32'h0002_0000);
        run_op(0, 8'd13, 8'd11, 1'b0, 16'd143, "rst_run/after");

        // Back-to-back with in_valid and out_ready held high.
        ba   = '{8'd3, 8'd200, 8'd17, 8'd1};
        bb   = '{8'd4, 8'd200, 8'd15, 8'd1};
        bexp = '{16'h000C, 16'h9C40, 16'h00FF, 16'h0001};
        acc  = '{0, 0, 0, 0};
        out_ready_s[0] = 1'b1;
        in_valid_s[0]  = 1'b1;
        a_s[0]         = ba[0];
        b_s[0]         = bb[0];
        is_signed_s[0] = 1'b0;
        k   = 0;
        j   = 0;
        t   = 0;
        adv = 1'b0;
        while (j < 4 && t < 80) begin
            if (adv) begin
                adv = 1'b0;
                if (k < 4) begin
                    a_s[0] = ba[k];
                    b_s[0] = bb[k];
                end else begin
                    in_valid_s[0] = 1'b0;
                end
            end
            if (in_ready_s[0] && k < 4) begin
                acc[k] = cyc + 1;
                k++;
                adv = 1'b1;
            end
            if (out_valid_s[0]) begin
                chk($sformatf("b2b/p%0d", j), 32'(p_s[0]), 32'(bexp[j]));
                j++;
            end
            @(posedge clk);
            #1;
            t++;
        end
        out_ready_s[0] = 1'b0;
        in_valid_s[0]  = 1'b0;
        chk("b2b/count", 32'(j), 32'd4);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("b2b/gap%0d", i), acc[i] - acc[i-1], 32'd10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
